// File: rtl/rpn_eval_ctrl.sv
// Reverse-Polish expression controller driving an external LIFO stack.
// Tracks stack occupancy itself and rejects tokens that would overflow or underflow it.
module rpn_eval_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [WIDTH-1:0]      tok_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_data_in,
  input  logic [WIDTH-1:0]      stk_data_out
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_EQ   = 2'b11;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UDF = 2'b10;

  typedef enum logic [2:0] {
    IDLE, PUSH_O, POP_B, POP_A, CALC, PUSH_R, EMIT
  } state_t;

  state_t             state, state_d;
  logic [CW-1:0]      depth_d;
  logic [1:0]         op, op_d;
  logic [WIDTH-1:0]   a, a_d, b, b_d;
  logic [WIDTH-1:0]   res_data_d, stk_data_in_d, alu_res;
  logic [PW-1:0]      prod;
  logic               res_valid_d, err_d, tok_ready_d, stk_push_d, stk_pop_d;
  logic [1:0]         err_code_d;

  // Deeper operand arrives on stk_data_out in CALC, the same cycle it is latched into a
  always_comb begin
    prod = PW'(stk_data_out) * PW'(b);
    case (op)
      OP_ADD:  alu_res = stk_data_out + b;
      OP_SUB:  alu_res = stk_data_out - b;
      OP_MUL:  alu_res = prod[WIDTH-1:0];
      default: alu_res = stk_data_out;
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    state_d       = state;
    depth_d       = depth;
    op_d          = op;
    a_d           = a;
    b_d           = b;
    res_valid_d   = res_valid;
    res_data_d    = res_data;
    err_d         = 1'b0;
    err_code_d    = err_code;
    stk_data_in_d = stk_data_in;

    case (state)
      IDLE: begin
        if (tok_valid && tok_ready) begin
          if (!tok_is_op) begin
            if (depth == CW'(DEPTH)) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVF;
            end else begin
              stk_data_in_d = tok_data;
              state_d       = PUSH_O;
            end
          end else begin
            op_d = tok_data[1:0];
            if ((tok_data[1:0] == OP_EQ) ? (depth == '0) : (depth < CW'(2))) begin
              err_d      = 1'b1;
              err_code_d = ERR_UDF;
            end else begin
              state_d = POP_B;
            end
          end
        end
      end
      PUSH_O: begin
        depth_d = depth + CW'(1);
        state_d = IDLE;
      end
      POP_B: begin
        depth_d = depth - CW'(1);
        state_d = (op == OP_EQ) ? EMIT : POP_A;
      end
      POP_A: begin
        depth_d = depth - CW'(1);
        b_d     = stk_data_out;
        state_d = CALC;
      end
      CALC: begin
        a_d           = stk_data_out;
        stk_data_in_d = alu_res;
        state_d       = PUSH_R;
      end
      PUSH_R: begin
        depth_d = depth + CW'(1);
        state_d = IDLE;
      end
      EMIT: begin
        // First EMIT cycle captures the popped value; valid is raised together with data
        if (!res_valid) begin
          res_data_d  = stk_data_out;
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tok_ready_d = (state_d == IDLE);
    stk_push_d  = (state_d == PUSH_O) || (state_d == PUSH_R);
    stk_pop_d   = (state_d == POP_B) || (state_d == POP_A);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      depth       <= '0;
      op          <= OP_ADD;
      a           <= '0;
      b           <= '0;
      tok_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
    end else begin
      state       <= state_d;
      depth       <= depth_d;
      op          <= op_d;
      a           <= a_d;
      b           <= b_d;
      tok_ready   <= tok_ready_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      err         <= err_d;
      err_code    <= err_code_d;
      stk_push    <= stk_push_d;
      stk_pop     <= stk_pop_d;
      stk_data_in <= stk_data_in_d;
    end
  end

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// Bench for rpn_eval_ctrl with a behavioural 8x8 LIFO attached and a result scoreboard.
module tb_rpn_eval_ctrl;

  localparam logic [7:0] T_ADD = 8'h00;
  localparam logic [7:0] T_SUB = 8'h01;
  localparam logic [7:0] T_MUL = 8'h02;
  localparam logic [7:0] T_EQ  = 8'h03;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tok_valid, tok_ready, tok_is_op;
  logic [7:0] tok_data;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       err;
  logic [1:0] err_code;
  logic [3:0] depth;
  logic       stk_push, stk_pop;
  logic [7:0] stk_data_in, stk_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl[$];
  int exp_q[$];

  logic [7:0] mem [8];
  int sp, n_push, n_pop;

  always #5 clk = ~clk;

  rpn_eval_ctrl #(.WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .err_code(err_code), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out)
  );

  // Behavioural stack: registered data_out, valid the cycle after pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp           <= 0;
      stk_data_out <= 8'h00;
      n_push       <= 0;
      n_pop        <= 0;
    end else if (stk_push) begin
      if (sp < 8) mem[sp] <= stk_data_in;
      sp     <= sp + 1;
      n_push <= n_push + 1;
    end else if (stk_pop) begin
      if (sp > 0) stk_data_out <= mem[sp-1];
      sp    <= sp - 1;
      n_pop <= n_pop + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("push_pop_excl", 32'(stk_push & stk_pop), 0);
      check("depth_range", 32'(depth > 4'd8), 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 1, 0);
        else check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one token, update the reference model, and check err/latency/depth
  task automatic send_tok(input logic is_op, input logic [7:0] data, input bit no_wait);
    int n, a_v, b_v, r, exp_lat;
    logic exp_err;
    logic [1:0] exp_code;
    exp_err = 1'b0; exp_code = 2'b00; exp_lat = 0;
    if (!is_op) begin
      if (mdl.size() == 8) begin exp_err = 1'b1; exp_code = 2'b01; exp_lat = 1; end
      else begin mdl.push_back(int'(data)); exp_lat = 2; end
    end else if (data[1:0] == 2'b11) begin
      if (mdl.size() == 0) begin exp_err = 1'b1; exp_code = 2'b10; exp_lat = 1; end
      else exp_q.push_back(mdl.pop_back());
    end else begin
      if (mdl.size() < 2) begin exp_err = 1'b1; exp_code = 2'b10; exp_lat = 1; end
      else begin
        b_v = mdl.pop_back();
        a_v = mdl.pop_back();
        case (data[1:0])
          2'b00:   r = a_v + b_v;
          2'b01:   r = a_v - b_v;
          default: r = a_v * b_v;
        endcase
        mdl.push_back(r & 255);
        exp_lat = 5;
      end
    end

    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = data;
    n = 0;
    while (!tok_ready && n < 100) begin @(negedge clk); n++; end
    if (!tok_ready) check("tok_ready_timeout", 0, 1);
    @(posedge clk); #1;
    tok_valid = 1'b0;
    check("err", 32'(err), 32'(exp_err));
    if (exp_err) check("err_code", 32'(err_code), 32'(exp_code));
    if (!exp_err && !is_op) check("push_next_cycle", 32'(stk_push), 1);
    if (no_wait) return;
    n = 1;
    while (!tok_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (exp_lat != 0) check("latency", n, exp_lat);
    else check("eq_done_timeout", 32'(tok_ready), 1);
    if (exp_err) begin
      @(posedge clk); #1;
      check("err_pulse", 32'(err), 0);
    end
    check("depth", 32'(depth), 32'(mdl.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int p0, q0, n;
    reset_n = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'h00; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tok_ready", 32'(tok_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_stk_data_in", 32'(stk_data_in), 0);
    check("rst_pushes", 32'(n_push), 0);
    check("rst_pops", 32'(n_pop), 0);

    // 3 4 + =
    p0 = n_push; q0 = n_pop;
    send_tok(0, 8'd3, 0); send_tok(0, 8'd4, 0); send_tok(1, T_ADD, 0); send_tok(1, T_EQ, 0);
    check("basic_pushes", 32'(n_push - p0), 3);
    check("basic_pops", 32'(n_pop - q0), 3);

    // Wrap-around arithmetic
    send_tok(0, 8'd10, 0);  send_tok(0, 8'd3, 0);   send_tok(1, T_SUB, 0); send_tok(1, T_EQ, 0);
    send_tok(0, 8'd3, 0);   send_tok(0, 8'd10, 0);  send_tok(1, T_SUB, 0); send_tok(1, T_EQ, 0);
    send_tok(0, 8'd20, 0);  send_tok(0, 8'd13, 0);  send_tok(1, T_MUL, 0); send_tok(1, T_EQ, 0);
    send_tok(0, 8'd200, 0); send_tok(0, 8'd100, 0); send_tok(1, T_ADD, 0); send_tok(1, T_EQ, 0);

    // Fill, overflow, then fold with ADDs
    for (int i = 1; i <= 8; i++) send_tok(0, 8'(i), 0);
    send_tok(0, 8'd9, 0);
    for (int i = 0; i < 7; i++) send_tok(1, T_ADD, 0);
    send_tok(1, T_EQ, 0);

    // Underflow on binary op and on empty EQ
    send_tok(0, 8'd5, 0);
    send_tok(1, T_ADD, 0);
    send_tok(1, T_EQ, 0);
    send_tok(1, T_EQ, 0);

    // Result back-pressure
    send_tok(0, 8'd5, 0); send_tok(0, 8'd6, 0); send_tok(1, T_MUL, 0);
    res_ready = 1'b0;
    send_tok(1, T_EQ, 1);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_valid_seen", 32'(res_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", 32'(res_valid), 1);
      check("hold_res_data", 32'(res_data), 30);
      check("hold_tok_ready", 32'(tok_ready), 0);
    end
    res_ready = 1'b1;
    n = 0;
    while (!tok_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_release_ready", 32'(tok_ready), 1);
    check("hold_depth", 32'(depth), 0);

    // Reset during POP_A
    send_tok(0, 8'd1, 0); send_tok(0, 8'd2, 0);
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = T_ADD;
    @(posedge clk); #1;
    tok_valid = 1'b0;
    @(posedge clk); #1;
    check("popa_pop", 32'(stk_pop), 1);
    reset_n = 1'b0;
    #1;
    mdl.delete();
    check("mid_rst_tok_ready", 32'(tok_ready), 1);
    check("mid_rst_depth", 32'(depth), 0);
    check("mid_rst_pop", 32'(stk_pop), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_push", 32'(stk_push), 0);
    check("post_rst_pop", 32'(stk_pop), 0);
    check("post_rst_depth", 32'(depth), 0);
    check("post_rst_tok_ready", 32'(tok_ready), 1);

    // Still functional after reset
    send_tok(0, 8'd9, 0); send_tok(1, T_EQ, 0);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
